// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole hit detector.
// Defaults for hole count, debounce length and hit index width.
package mole_pkg;
  localparam int N_HOLES_D = 4;
  localparam int DEBOUNCE_CYCLES_D = 16;
  localparam int IDX_W_D = $clog2(N_HOLES_D);
endpackage

// File: rtl/btn_debounce.sv
// Single-button 2-flop synchroniser, debouncer and press-edge detector.
// rise is registered and coincides with stable going 0->1.
module btn_debounce
  import mole_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= sync2;
          cnt    <= '0;
          rise   <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/mole_hit_detector.sv
// Debounces player buttons and judges presses against lit moles.
// Optional HIT_LOCKOUT_EN: one hit per lit period per hole.
module mole_hit_detector
  import mole_pkg::*;
#(
  parameter int N_HOLES = N_HOLES_D,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_D,
  parameter int IDX_W = IDX_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_HOLES-1:0] btn_raw,
  input  logic [N_HOLES-1:0] mole_active,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [IDX_W-1:0]   hit_index,
  output logic [N_HOLES-1:0] mole_clear
);
  logic [N_HOLES-1:0] stable;
  logic [N_HOLES-1:0] rise;
  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] hits;
  logic [N_HOLES-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_hit;
  logic               do_hit;

  for (genvar g = 0; g < N_HOLES; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[g]),
      .stable (stable[g]),
      .rise   (rise[g])
    );
  end

`ifdef HIT_LOCKOUT_EN
  logic [N_HOLES-1:0] lock;

  // lock survives only while the mole stays lit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock <= '0;
    else     lock <= (lock | (do_hit ? win_oh : '0)) & mole_active;
  end

  assign press = rise & ~lock;
`else
  assign press = rise;
`endif

  always_comb begin
    hits    = press & mole_active;
    any_hit = |hits;
    win_idx = '0;
    win_oh  = '0;
    for (int i = N_HOLES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        win_idx   = IDX_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign do_hit = enable & any_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hit_index  <= '0;
      mole_clear <= '0;
    end else begin
      hit_pulse  <= do_hit;
      miss_pulse <= enable & ~any_hit & (|press);
      mole_clear <= do_hit ? win_oh : '0;
      if (do_hit) hit_index <= win_idx;
    end
  end

  logic unused_ok;
  assign unused_ok = ^stable;
endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector, N_HOLES=4, DEBOUNCE_CYCLES=4.
// Honours HIT_LOCKOUT_EN when defined.
module tb_mole_hit_detector;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] btn_raw;
  logic [3:0] mole_active;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [1:0] hit_index;
  logic [3:0] mole_clear;

  int n_tests = 0;
  int n_fail  = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int both_cnt = 0;
  logic [1:0] last_idx;
  logic [3:0] last_clear;

  mole_hit_detector #(
    .N_HOLES(4),
    .DEBOUNCE_CYCLES(4),
    .IDX_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn_raw    (btn_raw),
    .mole_active(mole_active),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .hit_index  (hit_index),
    .mole_clear (mole_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (hit_pulse) begin
        hit_cnt    = hit_cnt + 1;
        last_idx   = hit_index;
        last_clear = mole_clear;
      end
      if (miss_pulse) miss_cnt = miss_cnt + 1;
      if (hit_pulse && miss_pulse) both_cnt = both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    hit_cnt  = 0;
    miss_cnt = 0;
  endtask

  task automatic tap(input logic [3:0] b);
    btn_raw = b;
    cyc(12);
    btn_raw = 4'b0000;
    cyc(12);
  endtask

  int exp_hits;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    btn_raw = 4'b0000;
    mole_active = 4'b0000;
    last_idx = '0;
    last_clear = '0;
    cyc(3);
    check("rst_hit", 32'(hit_pulse), 0);
    check("rst_miss", 32'(miss_pulse), 0);
    check("rst_idx", 32'(hit_index), 0);
    check("rst_clear", 32'(mole_clear), 0);
    rst = 1'b0;
    cyc(20);
    check("idle_hits", hit_cnt, 0);
    check("idle_miss", miss_cnt, 0);

    // single hit with exact latency
    enable = 1'b1;
    mole_active = 4'b0100;
    clr();
    btn_raw = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("lat_early", 32'(hit_pulse), 0);
      if (k == 7) begin
        check("lat_hit", 32'(hit_pulse), 1);
        check("lat_idx", 32'(hit_index), 2);
        check("lat_clear", 32'(mole_clear), 32'h4);
      end
    end
    cyc(10);
    check("held_hits", hit_cnt, 1);
    check("held_miss", miss_cnt, 0);
    check("idx_hold", 32'(hit_index), 2);
    check("clear_idle", 32'(mole_clear), 0);
    btn_raw = 4'b0000;
    cyc(12);

    // miss on unlit hole
    mole_active = 4'b0001;
    clr();
    tap(4'b1000);
    check("miss_cnt", miss_cnt, 1);
    check("miss_nohit", hit_cnt, 0);

    // bouncing button never settles
    clr();
    for (int r = 0; r < 6; r++) begin
      btn_raw = 4'b0010;
      cyc(2);
      btn_raw = 4'b0000;
      cyc(1);
    end
    cyc(8);
    check("bounce_quiet", hit_cnt + miss_cnt, 0);
    tap(4'b0010);
    check("bounce_event", miss_cnt, 1);
    check("bounce_nohit", hit_cnt, 0);

    // simultaneous presses, lowest lit wins
    mole_active = 4'b0010;
    clr();
    tap(4'b1010);
    check("dual_hits", hit_cnt, 1);
    check("dual_miss", miss_cnt, 0);
    check("dual_idx", 32'(last_idx), 1);
    check("dual_clear", 32'(last_clear), 32'h2);

    // press held across enable rising stays silent
    enable = 1'b0;
    mole_active = 4'b0001;
    cyc(2);
    clr();
    btn_raw = 4'b0001;
    cyc(12);
    enable = 1'b1;
    cyc(10);
    check("en_hold", hit_cnt + miss_cnt, 0);
    btn_raw = 4'b0000;
    cyc(12);

    // repeated presses on one lit hole
    clr();
    tap(4'b0001);
    tap(4'b0001);
`ifdef HIT_LOCKOUT_EN
    exp_hits = 1;
`else
    exp_hits = 2;
`endif
    check("repeat_hits", hit_cnt, exp_hits);
    check("repeat_miss", miss_cnt, 0);
    mole_active = 4'b0000;
    cyc(2);
    mole_active = 4'b0001;
    cyc(2);
    tap(4'b0001);
    check("relight_hits", hit_cnt, exp_hits + 1);
    check("relight_idx", 32'(last_idx), 0);
    check("relight_clear", 32'(last_clear), 32'h1);

    // async reset mid-pulse, then full re-debounce
    mole_active = 4'b0100;
    btn_raw = 4'b0100;
    cyc(7);
    check("pre_rst_hit", 32'(hit_pulse), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_hit", 32'(hit_pulse), 0);
    check("arst_idx", 32'(hit_index), 0);
    check("arst_clear", 32'(mole_clear), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("redb_early", 32'(hit_pulse), 0);
      if (k == 7) check("redb_hit", 32'(hit_pulse), 1);
    end
    btn_raw = 4'b0000;
    cyc(12);
    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
